// File: rtl/fp_int_to_fp_seq.sv
// Iterative int32/int64 to SP/DP converter (FCVT.{S,D}.{W,WU,L,LU}).
// Normalizes one bit per cycle, then rounds in a single cycle.
module fp_int_to_fp_seq #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_int_fmt,
  input  logic                  in_unsigned,
  input  logic                  in_fmt,
  input  logic [2:0]            in_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_flag_nx
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        fmt_q, fmt_d;
  logic [2:0]  rm_q, rm_d;
  logic        sign_q, sign_d;
  logic [63:0] mag_q, mag_d;
  logic [6:0]  lz_q, lz_d;
  logic [63:0] res_q, res_d;
  logic        nx_q, nx_d;

  logic [63:0] op_ext;
  logic        op_sign;
  logic [63:0] op_mag;

  always_comb begin
    if (in_int_fmt) begin
      op_ext = in_data;
    end else if (in_unsigned) begin
      op_ext = {32'b0, in_data[31:0]};
    end else begin
      op_ext = {{32{in_data[31]}}, in_data[31:0]};
    end
    op_sign = ~in_unsigned & op_ext[63];
    op_mag  = op_sign ? (~op_ext + 64'd1) : op_ext;
  end

  logic [6:0]  e;
  logic [7:0]  exp_sp;
  logic [10:0] exp_dp;
  logic        guard, sticky, lsb, inx, inc;
  logic [30:0] sp_sum;
  logic [62:0] dp_sum;
  logic [63:0] rnd_res;

  // Adding inc across {exp,mant} lets a mantissa carry bump the exponent
  always_comb begin
    e      = 7'd63 - lz_q;
    exp_sp = {1'b0, e} + 8'd127;
    exp_dp = {4'b0, e} + 11'd1023;
    if (fmt_q) begin
      guard  = mag_q[10];
      sticky = |mag_q[9:0];
      lsb    = mag_q[11];
    end else begin
      guard  = mag_q[39];
      sticky = |mag_q[38:0];
      lsb    = mag_q[40];
    end
    inx = guard | sticky;
    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = sign_q & inx;
      3'd3:    inc = ~sign_q & inx;
      3'd4:    inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
    sp_sum  = {exp_sp, mag_q[62:40]} + {30'b0, inc};
    dp_sum  = {exp_dp, mag_q[62:11]} + {62'b0, inc};
    rnd_res = fmt_q ? {sign_q, dp_sum}
                    : {32'hFFFF_FFFF, sign_q, sp_sum};
  end

  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    rm_d    = rm_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    lz_d    = lz_q;
    res_d   = res_q;
    nx_d    = nx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          fmt_d  = in_fmt;
          rm_d   = in_rm;
          sign_d = op_sign;
          mag_d  = op_mag;
          lz_d   = 7'd0;
          if (op_mag == 64'd0) begin
            res_d   = in_fmt ? 64'h0 : {32'hFFFF_FFFF, 32'h0};
            nx_d    = 1'b0;
            state_d = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[63]) begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + 7'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        res_d   = rnd_res;
        nx_d    = inx;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fmt_q   <= 1'b0;
      rm_q    <= 3'd0;
      sign_q  <= 1'b0;
      mag_q   <= 64'd0;
      lz_q    <= 7'd0;
      res_q   <= 64'd0;
      nx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fmt_q   <= fmt_d;
      rm_q    <= rm_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      lz_q    <= lz_d;
      res_q   <= res_d;
      nx_q    <= nx_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = res_q;
  assign out_flag_nx = nx_q;

endmodule

// File: tb/tb_fp_int_to_fp_seq.sv
// Randomized bench for fp_int_to_fp_seq against an arithmetic
// rounding model (quotient/remainder form), with pinned literals.
module tb_fp_int_to_fp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_int_fmt;
  logic        in_unsigned;
  logic        in_fmt;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_flag_nx;

  always #5 clk = ~clk;

  fp_int_to_fp_seq #(.DATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_int_fmt (in_int_fmt),
    .in_unsigned(in_unsigned),
    .in_fmt     (in_fmt),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_flag_nx(out_flag_nx)
  );

  typedef struct {
    logic [63:0] d;
    logic        nx;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t q[$];
  exp_t new_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   bp_hold = 1'b0;
  bit   rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Round via exact quotient and remainder of the magnitude
  function automatic exp_t model(input logic [63:0] din, input bit f64,
                                 input bit uns, input bit dp,
                                 input logic [2:0] rm);
    exp_t        r;
    longint      sv;
    logic [63:0] mag, qq, rem, half;
    bit          s, inc, nx;
    int          k, k0, p, sh;
    if (!f64) sv = uns ? longint'({32'b0, din[31:0]})
                       : longint'(signed'(din[31:0]));
    else sv = longint'(din);
    s = !uns && (sv < 0);
    mag = s ? 64'(-sv) : 64'(sv);
    r.seen = 1'b0;
    r.acc = 0;
    if (mag == 64'd0) begin
      r.d = dp ? 64'h0 : {32'hFFFF_FFFF, 32'h0};
      r.nx = 1'b0;
      r.lat = 1;
      return r;
    end
    k = 63;
    while (!mag[k]) k--;
    k0 = k;
    p = dp ? 53 : 24;
    inc = 1'b0;
    nx = 1'b0;
    if (k <= p - 1) begin
      qq = mag << (p - 1 - k);
    end else begin
      sh = k - (p - 1);
      qq = mag >> sh;
      rem = mag - (qq << sh);
      half = 64'd1 << (sh - 1);
      nx = (rem != 0);
      case (rm)
        3'd1: inc = 1'b0;
        3'd2: inc = s && nx;
        3'd3: inc = !s && nx;
        3'd4: inc = (rem >= half);
        default: inc = (rem > half) || ((rem == half) && qq[0]);
      endcase
      qq = qq + 64'(inc);
      if (qq == (64'd1 << p)) begin
        qq = qq >> 1;
        k++;
      end
    end
    if (dp) r.d = {s, 11'(k + 1023), qq[51:0]};
    else r.d = {32'hFFFF_FFFF, s, 8'(k + 127), qq[22:0]};
    r.nx = nx;
    r.lat = 66 - k0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        new_e = model(in_data, in_int_fmt, in_unsigned, in_fmt, in_rm);
        new_e.acc = cyc;
        q.push_back(new_e);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h expected none", out_data);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_nx", 64'(out_flag_nx), 64'(q[0].nx));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (!q[0].seen) begin
          q[0].seen = 1'b1;
          chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bp_hold) out_ready = 1'b0;
    else if (rnd_ready) out_ready = ($urandom % 4) != 0;
    else out_ready = 1'b1;
  end

  task automatic send(input logic [63:0] d, input bit f64, input bit uns,
                      input bit dp, input logic [2:0] rm);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    in_data = d;
    in_int_fmt = f64;
    in_unsigned = uns;
    in_fmt = dp;
    in_rm = rm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    in_int_fmt = 1'($urandom);
    in_unsigned = 1'($urandom);
    in_fmt = 1'($urandom);
    in_rm = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic pin(input string nm, input logic [63:0] d, input bit f64,
                     input bit uns, input bit dp, input logic [2:0] rm,
                     input logic [63:0] ed, input bit enx, input int elat);
    exp_t m;
    m = model(d, f64, uns, dp, rm);
    chk({nm, "_data"}, m.d, ed);
    chk({nm, "_nx"}, 64'(m.nx), 64'(enx));
    chk({nm, "_lat"}, 64'(m.lat), 64'(elat));
    send(d, f64, uns, dp, rm);
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held_d;
    logic        held_nx;
    int          n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 64'd0;
    in_int_fmt = 1'b0;
    in_unsigned = 1'b0;
    in_fmt = 1'b0;
    in_rm = 3'd0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_nx", 64'(out_flag_nx), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pin("one_sp", 64'd1, 0, 0, 0, 3'd0, 64'hFFFFFFFF3F800000, 0, 66);
    pin("m1_sp", 64'hFFFFFFFF, 0, 0, 0, 3'd0, 64'hFFFFFFFFBF800000, 0, 66);
    pin("u32_dp", 64'hFFFFFFFF, 0, 1, 1, 3'd0, 64'h41EFFFFFFFE00000, 0, 35);
    pin("p24_rne", 64'd16777217, 0, 0, 0, 3'd0, 64'hFFFFFFFF4B800000, 1, 42);
    pin("p24_rup", 64'd16777217, 0, 0, 0, 3'd3, 64'hFFFFFFFF4B800001, 1, 42);
    pin("p24_rtz", 64'd16777217, 0, 0, 0, 3'd1, 64'hFFFFFFFF4B800000, 1, 42);
    pin("n24_rdn", 64'hFEFFFFFF, 0, 0, 0, 3'd2, 64'hFFFFFFFFCB800001, 1, 42);
    pin("n24_rup", 64'hFEFFFFFF, 0, 0, 0, 3'd3, 64'hFFFFFFFFCB800000, 1, 42);
    pin("u64_rne", '1, 1, 1, 1, 3'd0, 64'h43F0000000000000, 1, 3);
    pin("u64_rtz", '1, 1, 1, 1, 3'd1, 64'h43EFFFFFFFFFFFFF, 1, 3);
    pin("min64", 64'h8000000000000000, 1, 0, 1, 3'd0,
        64'hC3E0000000000000, 0, 3);
    pin("zero_dp", 64'd0, 1, 0, 1, 3'd0, 64'h0, 0, 1);
    pin("zero_sp", 64'd0, 0, 1, 0, 3'd4, 64'hFFFFFFFF00000000, 0, 1);

    bp_hold = 1'b1;
    @(negedge clk);
    send(64'd12345, 0, 0, 1, 3'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 64'(out_valid), 64'd1);
    held_d = out_data;
    held_nx = out_flag_nx;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_data_hold", out_data, held_d);
      chk("bp_nx_hold", 64'(out_flag_nx), 64'(held_nx));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    bp_hold = 1'b0;
    drain();

    send(64'd1, 0, 0, 0, 3'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_no_stale", 64'(out_valid), 64'd0);

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom} >> $urandom_range(0, 64);
      if (($urandom % 16) == 0) d = {1'b1, 63'($urandom)};
      send(d, 1'($urandom), 1'($urandom), 1'($urandom),
           3'($urandom_range(0, 7)));
    end
    drain();
    rnd_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
